// File: rtl/div32_seq_pkg.sv
// ---------------------------------------------------------------------------
// div32_seq_pkg
//   Shared definitions for the sequential divider: FSM state encoding and the
//   iteration count of the restoring shift-subtract loop.
// ---------------------------------------------------------------------------
package div32_seq_pkg;

  // Two-bit state encoding: IDLE=0, DIV=1, FIX=2.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DIV  = 2'd1,
    ST_FIX  = 2'd2
  } state_e;

  // One quotient bit is produced per DIV cycle.
  localparam int unsigned ITERATIONS = 32;

  // Step counter width; must hold ITERATIONS-1.
  localparam int unsigned CNT_W = 6;

endpackage : div32_seq_pkg

// File: rtl/div32_seq_div_step.sv
// ---------------------------------------------------------------------------
// div32_seq_div_step
//   One purely combinational restoring-division iteration.
//   Ports:
//     rem_i      current partial remainder (always < divisor_i when divisor != 0)
//     dvd_msb_i  dividend bit shifted into the remainder this step
//     divisor_i  divisor magnitude
//     rem_o      partial remainder after the step
//     q_bit_o    quotient bit produced by the step
// ---------------------------------------------------------------------------
module div32_seq_div_step #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic             dvd_msb_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH-1:0] rem_o,
  output logic             q_bit_o
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] trial;

  always_comb begin
    shifted = {rem_i, dvd_msb_i};
    trial   = shifted - {1'b0, divisor_i};
    // Because rem_i < divisor_i, shifted < 2*divisor_i, so the WIDTH+1-bit
    // difference never wraps and its top bit is an exact sign.
    q_bit_o = ~trial[WIDTH];
    rem_o   = q_bit_o ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
  end

endmodule : div32_seq_div_step

// File: rtl/div32_seq.sv
// ---------------------------------------------------------------------------
// div32_seq
//   Sequential WIDTH-bit divider, restoring shift-subtract, one quotient bit
//   per cycle. LO receives the quotient, HI the remainder (remainder carries
//   the dividend's sign in signed mode). Fixed 33-cycle latency from START
//   acceptance to DONE, including divide by zero.
//   Ports:
//     CLK     rising-edge clock
//     RST     synchronous active-high reset
//     START   request pulse, sampled only in IDLE
//     SIGNED  1 = two's-complement divide, captured with START
//     A, B    dividend / divisor, captured with START
//     BUSY    high while in DIV or FIX
//     DONE    one-cycle pulse, HI/LO valid from this cycle
//     HI, LO  remainder / quotient, held until the next result
// ---------------------------------------------------------------------------
module div32_seq #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic             SIGNED,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             BUSY,
  output logic             DONE,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO
);

  import div32_seq_pkg::*;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q,   cnt_d;
  logic [WIDTH-1:0]   quo_q,   quo_d;    // dividend shifts out, quotient shifts in
  logic [WIDTH-1:0]   dvs_q,   dvs_d;    // divisor magnitude
  logic [WIDTH-1:0]   rem_q,   rem_d;    // partial remainder
  logic [WIDTH-1:0]   a_q,     a_d;      // original A, returned on divide by zero
  logic               q_neg_q, q_neg_d;
  logic               r_neg_q, r_neg_d;
  logic               dz_q,    dz_d;
  logic [WIDTH-1:0]   hi_q,    hi_d;
  logic [WIDTH-1:0]   lo_q,    lo_d;
  logic               done_q,  done_d;

  logic [WIDTH-1:0]   step_rem;
  logic               step_q_bit;
  logic               a_is_neg;
  logic               b_is_neg;

  div32_seq_div_step #(
    .WIDTH (WIDTH)
  ) u_div_step (
    .rem_i     (rem_q),
    .dvd_msb_i (quo_q[WIDTH-1]),
    .divisor_i (dvs_q),
    .rem_o     (step_rem),
    .q_bit_o   (step_q_bit)
  );

  assign a_is_neg = SIGNED & A[WIDTH-1];
  assign b_is_neg = SIGNED & B[WIDTH-1];

  always_comb begin
    // NOTE: every variable gets its hold value first so that no path through
    // the case statement leaves one unassigned and infers a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    quo_d   = quo_q;
    dvs_d   = dvs_q;
    rem_d   = rem_q;
    a_d     = a_q;
    q_neg_d = q_neg_q;
    r_neg_d = r_neg_q;
    dz_d    = dz_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (START) begin
          quo_d   = a_is_neg ? -A : A;
          dvs_d   = b_is_neg ? -B : B;
          a_d     = A;
          q_neg_d = a_is_neg ^ b_is_neg;
          r_neg_d = a_is_neg;
          dz_d    = (B == '0);
          rem_d   = '0;
          cnt_d   = '0;
          state_d = ST_DIV;
        end
      end

      ST_DIV: begin
        rem_d = step_rem;
        quo_d = {quo_q[WIDTH-2:0], step_q_bit};
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(ITERATIONS - 1)) begin
          state_d = ST_FIX;
        end
      end

      ST_FIX: begin
        if (dz_q) begin
          lo_d = '1;
          hi_d = a_q;
        end else begin
          lo_d = q_neg_q ? -quo_q : quo_q;
          hi_d = r_neg_q ? -rem_q : rem_q;
        end
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: all state, including the datapath registers, is cleared on reset so
  // an abandoned operation leaves nothing behind and HI/LO read zero.
  always_ff @(posedge CLK) begin
    // NOTE: non-blocking assignments so every flop samples the pre-edge value.
    if (RST) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      quo_q   <= '0;
      dvs_q   <= '0;
      rem_q   <= '0;
      a_q     <= '0;
      q_neg_q <= 1'b0;
      r_neg_q <= 1'b0;
      dz_q    <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      quo_q   <= quo_d;
      dvs_q   <= dvs_d;
      rem_q   <= rem_d;
      a_q     <= a_d;
      q_neg_q <= q_neg_d;
      r_neg_q <= r_neg_d;
      dz_q    <= dz_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
    end
  end

  assign BUSY = (state_q == ST_DIV) || (state_q == ST_FIX);
  assign DONE = done_q;
  assign HI   = hi_q;
  assign LO   = lo_q;

endmodule : div32_seq

// File: tb/tb_div32_seq.sv
// ---------------------------------------------------------------------------
// tb_div32_seq
//   Directed and randomized checks of div32_seq: reset, latency/BUSY timing,
//   signed/unsigned results, overflow, divide by zero, START while busy,
//   back-to-back operation and reset in mid-operation.
// ---------------------------------------------------------------------------
module tb_div32_seq;

  logic        CLK = 1'b0;
  logic        RST;
  logic        START;
  logic        SIGNED;
  logic [31:0] A;
  logic [31:0] B;
  logic        BUSY;
  logic        DONE;
  logic [31:0] HI;
  logic [31:0] LO;

  int total = 0;
  int bad   = 0;

  always #5 CLK = ~CLK;

  div32_seq #(.WIDTH(32)) dut (
    .CLK    (CLK),
    .RST    (RST),
    .START  (START),
    .SIGNED (SIGNED),
    .A      (A),
    .B      (B),
    .BUSY   (BUSY),
    .DONE   (DONE),
    .HI     (HI),
    .LO     (LO)
  );

  // Advance one clock; inputs are driven and outputs sampled 1 time unit
  // after the rising edge.
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Present an operation for one edge, then scramble the operand inputs.
  task automatic do_start(input logic [31:0] a, input logic [31:0] b, input logic s);
    A      = a;
    B      = b;
    SIGNED = s;
    START  = 1'b1;
    step();
    START  = 1'b0;
    A      = $urandom;
    B      = $urandom;
    SIGNED = 1'($urandom_range(0, 1));
  endtask

  // Called right after the accepting edge. lat = cycles until DONE seen
  // (-1 on timeout); busy_cnt = BUSY samples before DONE.
  task automatic wait_done(output int lat, output int busy_cnt);
    lat      = -1;
    busy_cnt = 0;
    for (int n = 0; n < 45; n++) begin
      if (DONE === 1'b1) begin
        lat = n;
        break;
      end
      if (BUSY === 1'b1) busy_cnt++;
      step();
    end
  endtask

  task automatic test_reset();
    RST = 1'b1; START = 1'b1; SIGNED = 1'b0; A = 32'd100; B = 32'd7;
    step();
    step();
    total++; if (BUSY !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", BUSY); end
    total++; if (DONE !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", DONE); end
    total++; if (HI !== 32'h0) begin bad++; $display("FAIL reset_hi got=%h want=00000000", HI); end
    total++; if (LO !== 32'h0) begin bad++; $display("FAIL reset_lo got=%h want=00000000", LO); end
    RST = 1'b0; START = 1'b0;
    step();
    total++; if (BUSY !== 1'b0) begin bad++; $display("FAIL reset_start_dropped got=%b want=0", BUSY); end
  endtask

  task automatic test_unsigned_basic();
    int lat, busy_cnt;
    do_start(32'd100, 32'd7, 1'b0);
    total++; if (BUSY !== 1'b1) begin bad++; $display("FAIL basic_busy_after_accept got=%b want=1", BUSY); end
    wait_done(lat, busy_cnt);
    total++; if (lat !== 33) begin bad++; $display("FAIL basic_latency got=%0d want=33", lat); end
    total++; if (busy_cnt !== 33) begin bad++; $display("FAIL basic_busy_cycles got=%0d want=33", busy_cnt); end
    total++; if (BUSY !== 1'b0) begin bad++; $display("FAIL basic_busy_at_done got=%b want=0", BUSY); end
    total++; if (LO !== 32'd14) begin bad++; $display("FAIL basic_lo got=%h want=0000000e", LO); end
    total++; if (HI !== 32'd2) begin bad++; $display("FAIL basic_hi got=%h want=00000002", HI); end
    step();
    total++; if (DONE !== 1'b0) begin bad++; $display("FAIL basic_done_pulse got=%b want=0", DONE); end
    total++; if (LO !== 32'd14 || HI !== 32'd2) begin
      bad++; $display("FAIL basic_hold got=%h/%h want=00000002/0000000e", HI, LO);
    end
  endtask

  task automatic test_vectors();
    logic [31:0] va  [8] = '{32'hFFFFFFF9, 32'hFFFFFFF9, 32'h80000000, 32'd5,
                             32'hFFFFFFF9, 32'd7,      32'hFFFFFFF9, 32'hFFFFFFFF};
    logic [31:0] vb  [8] = '{32'd2,        32'd2,      32'hFFFFFFFF, 32'd0,
                             32'd0,        32'hFFFFFFFE, 32'hFFFFFFFE, 32'd1};
    logic        vs  [8] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [31:0] vlo [8] = '{32'hFFFFFFFD, 32'h7FFFFFFC, 32'h80000000, 32'hFFFFFFFF,
                             32'hFFFFFFFF, 32'hFFFFFFFD, 32'd3,        32'hFFFFFFFF};
    logic [31:0] vhi [8] = '{32'hFFFFFFFF, 32'd1,      32'd0,      32'd5,
                             32'hFFFFFFF9, 32'd1,      32'hFFFFFFFF, 32'd0};
    int lat, busy_cnt;
    for (int i = 0; i < 8; i++) begin
      do_start(va[i], vb[i], vs[i]);
      wait_done(lat, busy_cnt);
      total++; if (lat !== 33) begin bad++; $display("FAIL vec%0d_latency got=%0d want=33", i, lat); end
      total++; if (LO !== vlo[i]) begin bad++; $display("FAIL vec%0d_lo got=%h want=%h", i, LO, vlo[i]); end
      total++; if (HI !== vhi[i]) begin bad++; $display("FAIL vec%0d_hi got=%h want=%h", i, HI, vhi[i]); end
    end
  endtask

  task automatic test_start_while_busy();
    int lat, busy_cnt, extra;
    do_start(32'd100, 32'd7, 1'b0);
    for (int n = 0; n < 9; n++) step();
    A = 32'd1000; B = 32'd3; SIGNED = 1'b1; START = 1'b1;
    step();
    START = 1'b0;
    wait_done(lat, busy_cnt);
    total++; if (lat !== 23) begin bad++; $display("FAIL busy_start_latency got=%0d want=23", lat); end
    total++; if (LO !== 32'd14) begin bad++; $display("FAIL busy_start_lo got=%h want=0000000e", LO); end
    total++; if (HI !== 32'd2) begin bad++; $display("FAIL busy_start_hi got=%h want=00000002", HI); end
    extra = 0;
    for (int n = 0; n < 40; n++) begin
      step();
      if (DONE !== 1'b0 || BUSY !== 1'b0) extra++;
    end
    total++; if (extra !== 0) begin bad++; $display("FAIL busy_start_no_second_op got=%0d want=0", extra); end
  endtask

  task automatic test_back_to_back();
    int lat, busy_cnt;
    do_start(32'd100, 32'd7, 1'b0);
    wait_done(lat, busy_cnt);
    total++; if (lat !== 33) begin bad++; $display("FAIL b2b_first_latency got=%0d want=33", lat); end
    // Still in the DONE cycle: the next START is accepted at the coming edge.
    do_start(32'hFFFFFFF9, 32'd2, 1'b1);
    total++; if (BUSY !== 1'b1) begin bad++; $display("FAIL b2b_accept got=%b want=1", BUSY); end
    total++; if (LO !== 32'd14 || HI !== 32'd2) begin
      bad++; $display("FAIL b2b_hold got=%h/%h want=00000002/0000000e", HI, LO);
    end
    wait_done(lat, busy_cnt);
    total++; if (lat !== 33) begin bad++; $display("FAIL b2b_second_latency got=%0d want=33", lat); end
    total++; if (LO !== 32'hFFFFFFFD) begin bad++; $display("FAIL b2b_lo got=%h want=fffffffd", LO); end
    total++; if (HI !== 32'hFFFFFFFF) begin bad++; $display("FAIL b2b_hi got=%h want=ffffffff", HI); end
  endtask

  task automatic test_reset_mid_op();
    int lat, busy_cnt, dones;
    do_start(32'd100, 32'd7, 1'b0);
    for (int n = 0; n < 9; n++) step();
    RST = 1'b1; START = 1'b1; A = 32'd50; B = 32'd5; SIGNED = 1'b0;
    step();
    total++; if (BUSY !== 1'b0) begin bad++; $display("FAIL midrst_busy got=%b want=0", BUSY); end
    total++; if (DONE !== 1'b0) begin bad++; $display("FAIL midrst_done got=%b want=0", DONE); end
    total++; if (HI !== 32'h0 || LO !== 32'h0) begin
      bad++; $display("FAIL midrst_outputs got=%h/%h want=00000000/00000000", HI, LO);
    end
    RST = 1'b0; START = 1'b0;
    dones = 0;
    for (int n = 0; n < 40; n++) begin
      step();
      if (DONE !== 1'b0) dones++;
    end
    total++; if (dones !== 0) begin bad++; $display("FAIL midrst_no_done got=%0d want=0", dones); end
    do_start(32'hFFFFFFF9, 32'd2, 1'b0);
    wait_done(lat, busy_cnt);
    total++; if (lat !== 33) begin bad++; $display("FAIL midrst_after_latency got=%0d want=33", lat); end
    total++; if (LO !== 32'h7FFFFFFC || HI !== 32'd1) begin
      bad++; $display("FAIL midrst_after_result got=%h/%h want=00000001/7ffffffc", HI, LO);
    end
  endtask

  task automatic test_random();
    int lat, busy_cnt;
    logic [31:0] a, b, exp_q, exp_r;
    logic        s;
    for (int i = 0; i < 1000; i++) begin
      a = $urandom;
      b = ($urandom_range(0, 1) == 1) ? 32'($urandom_range(1, 1000)) : $urandom;
      if ($urandom_range(0, 3) == 0) b = -b;
      if (b == 32'h0) b = 32'd1;
      s = 1'($urandom_range(0, 1));
      if (s && a == 32'h80000000 && b == 32'hFFFFFFFF) b = 32'd3;
      if (s) begin
        int sa, sb;
        sa    = int'(a);
        sb    = int'(b);
        exp_q = 32'(sa / sb);
        exp_r = 32'(sa % sb);
      end else begin
        exp_q = a / b;
        exp_r = a % b;
      end
      do_start(a, b, s);
      wait_done(lat, busy_cnt);
      total++; if (lat !== 33) begin bad++; $display("FAIL rand%0d_latency got=%0d want=33", i, lat); end
      total++; if (LO !== exp_q || HI !== exp_r) begin
        bad++;
        $display("FAIL rand%0d_result a=%h b=%h s=%b got=%h/%h want=%h/%h",
                 i, a, b, s, HI, LO, exp_r, exp_q);
      end
    end
  endtask

  initial begin
    RST = 1'b1; START = 1'b0; SIGNED = 1'b0; A = '0; B = '0;
    #1;
    test_reset();
    test_unsigned_basic();
    test_vectors();
    test_start_while_busy();
    test_back_to_back();
    test_reset_mid_op();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_div32_seq
